random_delay: RTL and testbench

RANDOM_DELAY -- requirements
Module: random_delay

---
 rtl/random_delay.sv | 112 +++++++++++
 tb/tb_random_delay.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/random_delay.sv
// Random-length wait timer: latches MIN_MS + a RAND_BITS random pool on start and counts it down in ms ticks.
// Optional cancel input/pulse enabled by defining RANDOM_DELAY_ABORT_EN.
module random_delay #(
  parameter int TICK_DIV  = 100000,
  parameter int MIN_MS    = 1000,
  parameter int RAND_BITS = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r_in,
  input  logic        start,
`ifdef RANDOM_DELAY_ABORT_EN
  input  logic        abort,
  output logic        aborted,
`endif
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] delay_ms
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FW = $clog2(RAND_BITS + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t               state_q, state_d;
  logic [RAND_BITS-1:0] pool_q;
  logic [FW-1:0]        fill_q;
  logic [15:0]          rem_q, rem_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [15:0]          delay_q, delay_d;
  logic                 filled, tick;
  logic [15:0]          sum;
`ifdef RANDOM_DELAY_ABORT_EN
  logic                 aborted_q, abort_hit;
`endif

  assign filled = (fill_q == FW'(RAND_BITS));
  assign tick   = (presc_q == PW'(TICK_DIV - 1));
  // The pool value before this edge's shift is what gets captured.
  assign sum    = 16'(MIN_MS) + 16'(pool_q);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    presc_d = presc_q;
    delay_d = delay_q;
`ifdef RANDOM_DELAY_ABORT_EN
    abort_hit = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start && filled) begin
          state_d = WAIT;
          delay_d = sum;
          rem_d   = sum;
          presc_d = '0;
        end
      end
      WAIT: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = DONE;
        end
`ifdef RANDOM_DELAY_ABORT_EN
        // Cancel takes priority over a coincident final tick.
        if (abort) begin
          state_d   = IDLE;
          abort_hit = 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pool_q  <= '0;
      fill_q  <= '0;
      rem_q   <= '0;
      presc_q <= '0;
      delay_q <= '0;
`ifdef RANDOM_DELAY_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pool_q  <= {pool_q[RAND_BITS-2:0], r_in};
      if (!filled) fill_q <= fill_q + FW'(1);
      rem_q   <= rem_d;
      presc_q <= presc_d;
      delay_q <= delay_d;
`ifdef RANDOM_DELAY_ABORT_EN
      aborted_q <= abort_hit;
`endif
    end
  end

  assign ready    = (state_q == IDLE) && filled;
  assign busy     = (state_q == WAIT);
  assign done     = (state_q == DONE);
  assign delay_ms = delay_q;
`ifdef RANDOM_DELAY_ABORT_EN
  assign aborted  = aborted_q;
`endif

endmodule

// File: tb/tb_random_delay.sv
// Self-checking bench for random_delay (TICK_DIV=4, MIN_MS=2, RAND_BITS=3): vector table plus
// hand-written corner sequences; done pulses are checked against a queue of expected events.
module tb_random_delay;
  localparam int T = 4;
  localparam int M = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        r_in = 1'b0;
  logic        start = 1'b0;
  logic        ready, busy, done;
  logic [15:0] delay_ms;
`ifdef RANDOM_DELAY_ABORT_EN
  logic        abort = 1'b0;
  logic        aborted;
`endif

  random_delay #(.TICK_DIV(T), .MIN_MS(M), .RAND_BITS(3)) dut (
    .clk(clk), .reset(reset), .r_in(r_in), .start(start),
`ifdef RANDOM_DELAY_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .ready(ready), .busy(busy), .done(done), .delay_ms(delay_ms)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [15:0] d; } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always begin
    @(posedge clk);
    #2;
    if (done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("done_delay", delay_ms, e.d);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; r_in = 1'b0;
    step();
    sb.delete();
  endtask

  // Release reset and shift in three bits, MSB first.
  task automatic fill(input logic [2:0] b);
    reset = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      r_in = b[i];
      step();
    end
    r_in = 1'b0;
  endtask

  task automatic launch(input string name, input int exp_d);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({name, "_busy"}, busy, 1);
    chk({name, "_delay"}, delay_ms, exp_d);
    sb.push_back('{cyc + exp_d * T, 16'(exp_d)});
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      step();
      n++;
    end
    chk({name, "_timeout"}, int'(sb.size() != 0), 0);
  endtask

  typedef struct { logic [2:0] bits; int exp_d; } vec_t;
  vec_t vecs[5];

  initial begin
    vecs[0] = '{3'b101, 7};
    vecs[1] = '{3'b000, 2};
    vecs[2] = '{3'b111, 9};
    vecs[3] = '{3'b011, 5};
    vecs[4] = '{3'b100, 6};

    step(); step();
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_delay", delay_ms, 0);

    foreach (vecs[i]) begin
      do_reset();
      fill(vecs[i].bits);
      chk("vec_ready_pre", ready, 1);
      launch($sformatf("vec%0d", i), vecs[i].exp_d);
      wait_done($sformatf("vec%0d", i));
      chk("vec_ready_post", ready, 1);
      chk("vec_busy_post", busy, 0);
    end

    // Early starts ignored until the pool has seen three shifts; re-pulses mid-wait ignored.
    do_reset();
    reset = 1'b0; r_in = 1'b1; start = 1'b1;
    step(); chk("early1_busy", busy, 0); chk("early1_ready", ready, 0);
    step(); chk("early2_busy", busy, 0); chk("early2_ready", ready, 0);
    step(); chk("early3_busy", busy, 0); chk("early3_ready", ready, 1);
    step(); start = 1'b0; r_in = 1'b0;
    chk("late_busy", busy, 1);
    chk("late_delay", delay_ms, 9);
    sb.push_back('{cyc + 9 * T, 16'd9});
    repeat (4) step();
    start = 1'b1; step(); start = 1'b0;
    repeat (4) step();
    start = 1'b1; step(); start = 1'b0;
    chk("repulse_delay", delay_ms, 9);
    chk("repulse_busy", busy, 1);
    wait_done("repulse");

    // Reset mid-wait abandons it with no done.
    do_reset();
    fill(3'b101);
    launch("rstmid", 7);
    repeat (9) step();
    reset = 1'b1;
    step();
    sb.delete();
    chk("rstmid_ready", ready, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_delay", delay_ms, 0);
    reset = 1'b0; step();
    start = 1'b1; step(); start = 1'b0;
    chk("rstmid_start_ign", busy, 0);
    repeat (40) step();
    chk("rstmid_no_done_q", sb.size(), 0);

`ifdef RANDOM_DELAY_ABORT_EN
    do_reset();
    fill(3'b101);
    launch("ab12", 7);
    repeat (11) step();
    abort = 1'b1; step(); abort = 1'b0;
    sb.delete();
    chk("ab12_aborted", aborted, 1);
    chk("ab12_busy", busy, 0);
    step();
    chk("ab12_pulse_len", aborted, 0);
    do_reset();
    fill(3'b000);
    launch("abfin", 2);
    repeat (7) step();
    abort = 1'b1; step(); abort = 1'b0;
    sb.delete();
    chk("abfin_aborted", aborted, 1);
    chk("abfin_done", done, 0);
    repeat (5) step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
